// File: rtl/bus_rx_sequencer.sv
// Read-burst sequencer for the bus byte/bit receiver: issues byte and T-bit requests,
// checks odd parity per byte and hands bytes to the target FIFO through a valid/ready register.
module bus_rx_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             cmd_tbit_en_i,
  input  logic             abort_i,
  output logic             rx_req_byte_o,
  output logic             rx_req_bit_o,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_done_i,
  input  logic             rx_error_i,
  output logic [7:0]       data_o,
  output logic             data_err_o,
  output logic             data_last_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic [LEN_W-1:0] bytes_rcvd_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             parity_err_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ_BYTE,
    REQ_TBIT
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic             tbit_en_q;
  logic [7:0]       stage_q;
  logic [7:0]       data_q;
  logic             data_err_q;
  logic             data_last_q;
  logic             data_valid_q;
  logic             done_q;
  logic             aborted_q;
  logic             parity_err_q;
  logic             overflow_q;

  logic             stop;
  logic             push;
  logic [7:0]       push_data;
  logic             push_err;
  logic             push_last;
  logic             out_free;
  logic [LEN_W-1:0] count_next;

  assign stop       = abort_i | rx_error_i;
  assign count_next = count_q + 1'b1;
  assign push_last  = (count_next == len_q);
  assign out_free   = ~data_valid_q | data_ready_i;

  // A byte completes on the byte done (no T-bit) or on the T-bit done; an abort in the same cycle wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    push      = 1'b0;
    push_data = rx_data_i;
    push_err  = 1'b0;
    if (rx_done_i && !stop) begin
      case (state_q)
        REQ_BYTE: push = ~tbit_en_q;
        REQ_TBIT: begin
          push      = 1'b1;
          push_data = stage_q;
          push_err  = rx_data_i[0] != ~^stage_q;
        end
        default: push = 1'b0;
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      count_q      <= '0;
      tbit_en_q    <= 1'b0;
      stage_q      <= '0;
      data_q       <= '0;
      data_err_q   <= 1'b0;
      data_last_q  <= 1'b0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;

      if (data_valid_q && data_ready_i) data_valid_q <= 1'b0;

      // A push into a full, stalled output stage is dropped but still counted.
      if (push) begin
        count_q      <= count_next;
        parity_err_q <= push_err;
        if (out_free) begin
          data_q       <= push_data;
          data_err_q   <= push_err;
          data_last_q  <= push_last;
          data_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid_i && !abort_i) begin
            count_q <= '0;
            if (cmd_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              len_q     <= cmd_len_i;
              tbit_en_q <= cmd_tbit_en_i;
              state_q   <= REQ_BYTE;
            end
          end
        end
        default: begin
          if (stop) begin
            state_q   <= IDLE;
            aborted_q <= 1'b1;
          end else if (rx_done_i) begin
            if (state_q == REQ_BYTE) stage_q <= rx_data_i;
            if (push) begin
              if (push_last) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= REQ_BYTE;
              end
            end else begin
              state_q <= REQ_TBIT;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rx_req_byte_o = (state_q == REQ_BYTE);
  assign rx_req_bit_o  = (state_q == REQ_TBIT);
  assign data_o        = data_q;
  assign data_err_o    = data_err_q;
  assign data_last_o   = data_last_q;
  assign data_valid_o  = data_valid_q;
  assign bytes_rcvd_o  = count_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign parity_err_o  = parity_err_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_bus_rx_sequencer.sv
// Scoreboard bench for bus_rx_sequencer: a receiver model answers requests, expected output
// bytes are queued as stimulus is driven and compared on each output handshake.
module tb_bus_rx_sequencer;

  localparam int LEN_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_len_i;
  logic             cmd_tbit_en_i;
  logic             abort_i;
  logic             rx_req_byte_o;
  logic             rx_req_bit_o;
  logic [7:0]       rx_data_i;
  logic             rx_done_i;
  logic             rx_error_i;
  logic [7:0]       data_o;
  logic             data_err_o;
  logic             data_last_o;
  logic             data_valid_o;
  logic             data_ready_i;
  logic [LEN_W-1:0] bytes_rcvd_o;
  logic             done_o;
  logic             aborted_o;
  logic             parity_err_o;
  logic             overflow_o;

  bus_rx_sequencer #(.LEN_W(LEN_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_len_i     (cmd_len_i),
    .cmd_tbit_en_i (cmd_tbit_en_i),
    .abort_i       (abort_i),
    .rx_req_byte_o (rx_req_byte_o),
    .rx_req_bit_o  (rx_req_bit_o),
    .rx_data_i     (rx_data_i),
    .rx_done_i     (rx_done_i),
    .rx_error_i    (rx_error_i),
    .data_o        (data_o),
    .data_err_o    (data_err_o),
    .data_last_o   (data_last_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .bytes_rcvd_o  (bytes_rcvd_o),
    .done_o        (done_o),
    .aborted_o     (aborted_o),
    .parity_err_o  (parity_err_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       l;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_done, n_abort, n_perr, n_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic e, input logic l);
    exp_t x;
    x.d = d;
    x.e = e;
    x.l = l;
    sb_q.push_back(x);
  endtask

  // Output monitor, sampling mid-cycle after the driver has settled its inputs.
  always @(negedge clk_i) begin
    #1;
    if (!rst_i) begin
      check("req_excl", 32'(rx_req_byte_o & rx_req_bit_o), 0);
      if (done_o)       n_done++;
      if (aborted_o)    n_abort++;
      if (parity_err_o) n_perr++;
      if (overflow_o)   n_ovf++;
      if (data_valid_o && data_ready_i) begin
        check("sb_has_entry", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          exp_t x;
          x = sb_q.pop_front();
          check("data", 32'(data_o), 32'(x.d));
          check("data_err", 32'(data_err_o), 32'(x.e));
          check("data_last", 32'(data_last_o), 32'(x.l));
        end
      end
    end
  end

  task automatic clear_counts();
    n_done  = 0;
    n_abort = 0;
    n_perr  = 0;
    n_ovf   = 0;
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic tbit);
    cmd_valid_i   = 1'b1;
    cmd_len_i     = len;
    cmd_tbit_en_i = tbit;
    check("cmd_ready", 32'(cmd_ready_o), 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  // Receiver model: wait (bounded) for the requested kind, then return one done pulse.
  task automatic rx_respond(input logic want_bit, input logic [7:0] d);
    int n = 0;
    while (!(want_bit ? rx_req_bit_o : rx_req_byte_o) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check(want_bit ? "req_bit_seen" : "req_byte_seen",
          32'(want_bit ? rx_req_bit_o : rx_req_byte_o), 1);
    rx_data_i = d;
    rx_done_i = 1'b1;
    @(negedge clk_i);
    rx_done_i = 1'b0;
    rx_data_i = '0;
  endtask

  task automatic settle();
    int n = 0;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("back_to_idle", 32'(cmd_ready_o), 1);
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i         = 1'b1;
    cmd_valid_i   = 1'b0;
    cmd_len_i     = '0;
    cmd_tbit_en_i = 1'b0;
    abort_i       = 1'b0;
    rx_data_i     = '0;
    rx_done_i     = 1'b0;
    rx_error_i    = 1'b0;
    data_ready_i  = 1'b1;
    clear_counts();

    repeat (3) @(negedge clk_i);
    check("rst_cmd_ready", 32'(cmd_ready_o), 1);
    check("rst_reqs", 32'({rx_req_byte_o, rx_req_bit_o}), 0);
    check("rst_data", 32'({data_o, data_err_o, data_last_o, data_valid_o}), 0);
    check("rst_status", 32'({bytes_rcvd_o, done_o, aborted_o, parity_err_o, overflow_o}), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Two bytes with good odd parity: 0xA5 and 0x3C each have four ones, so T=1.
    clear_counts();
    expect_byte(8'hA5, 1'b0, 1'b0);
    expect_byte(8'h3C, 1'b0, 1'b1);
    send_cmd(8'd2, 1'b1);
    rx_respond(1'b0, 8'hA5);
    rx_respond(1'b1, 8'h01);
    rx_respond(1'b0, 8'h3C);
    rx_respond(1'b1, 8'h01);
    settle();
    check("t1_done", n_done, 1);
    check("t1_perr", n_perr, 0);
    check("t1_ovf", n_ovf, 0);
    check("t1_abort", n_abort, 0);
    check("t1_bytes", 32'(bytes_rcvd_o), 2);
    check("t1_sb_empty", sb_q.size(), 0);

    // 0x01 needs T=0 for odd parity; T=1 is a mismatch.
    clear_counts();
    expect_byte(8'h01, 1'b1, 1'b1);
    send_cmd(8'd1, 1'b1);
    rx_respond(1'b0, 8'h01);
    rx_respond(1'b1, 8'h01);
    settle();
    check("t2_perr", n_perr, 1);
    check("t2_done", n_done, 1);
    check("t2_sb_empty", sb_q.size(), 0);

    // Stalled output: first byte held, the next two dropped with overflow.
    clear_counts();
    data_ready_i = 1'b0;
    expect_byte(8'h11, 1'b0, 1'b0);
    send_cmd(8'd3, 1'b0);
    rx_respond(1'b0, 8'h11);
    rx_respond(1'b0, 8'h22);
    rx_respond(1'b0, 8'h33);
    settle();
    check("t3_ovf", n_ovf, 2);
    check("t3_bytes", 32'(bytes_rcvd_o), 3);
    check("t3_done", n_done, 1);
    check("t3_held_valid", 32'(data_valid_o), 1);
    check("t3_held_data", 32'(data_o), 32'h11);
    data_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("t3_drained", 32'(data_valid_o), 0);
    check("t3_sb_empty", sb_q.size(), 0);

    // Abort during the 2nd byte, coinciding with its done: the byte is discarded.
    clear_counts();
    expect_byte(8'h55, 1'b0, 1'b0);
    send_cmd(8'd4, 1'b0);
    rx_respond(1'b0, 8'h55);
    check("t4_req_byte2", 32'(rx_req_byte_o), 1);
    abort_i   = 1'b1;
    rx_done_i = 1'b1;
    rx_data_i = 8'h66;
    @(negedge clk_i);
    abort_i   = 1'b0;
    rx_done_i = 1'b0;
    rx_data_i = '0;
    check("t4_reqs_low", 32'({rx_req_byte_o, rx_req_bit_o}), 0);
    check("t4_aborted", 32'(aborted_o), 1);
    check("t4_bytes", 32'(bytes_rcvd_o), 1);
    settle();
    check("t4_abort_cnt", n_abort, 1);
    check("t4_no_done", n_done, 0);
    check("t4_sb_empty", sb_q.size(), 0);

    // Receiver error while waiting for the T-bit ends the burst the same way.
    clear_counts();
    send_cmd(8'd2, 1'b1);
    rx_respond(1'b0, 8'h0F);
    check("t5_req_bit", 32'(rx_req_bit_o), 1);
    rx_error_i = 1'b1;
    @(negedge clk_i);
    rx_error_i = 1'b0;
    check("t5_reqs_low", 32'({rx_req_byte_o, rx_req_bit_o}), 0);
    check("t5_aborted", 32'(aborted_o), 1);
    check("t5_bytes", 32'(bytes_rcvd_o), 0);
    settle();
    check("t5_no_done", n_done, 0);
    check("t5_sb_empty", sb_q.size(), 0);

    // Zero-length command: done the cycle after acceptance, never leaves Idle.
    clear_counts();
    send_cmd(8'd0, 1'b1);
    check("t6_done", 32'(done_o), 1);
    check("t6_cmd_ready", 32'(cmd_ready_o), 1);
    check("t6_reqs", 32'({rx_req_byte_o, rx_req_bit_o}), 0);
    @(negedge clk_i);
    check("t6_done_pulse", 32'(done_o), 0);

    // Command together with abort while Idle is rejected.
    cmd_valid_i = 1'b1;
    cmd_len_i   = 8'd5;
    abort_i     = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    abort_i     = 1'b0;
    check("t7_rejected", 32'({cmd_ready_o, rx_req_byte_o}), 32'b10);
    @(negedge clk_i);
    check("t7_still_idle", 32'(rx_req_byte_o), 0);

    // Reset in the middle of a T-bit request with a byte pending at the output.
    clear_counts();
    data_ready_i = 1'b0;
    send_cmd(8'd2, 1'b1);
    rx_respond(1'b0, 8'hA5);
    rx_respond(1'b1, 8'h01);
    rx_respond(1'b0, 8'h3C);
    check("t8_pending", 32'(data_valid_o), 1);
    check("t8_in_tbit", 32'(rx_req_bit_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("t8_rst_req", 32'({rx_req_byte_o, rx_req_bit_o}), 0);
    check("t8_rst_valid", 32'(data_valid_o), 0);
    check("t8_rst_ready", 32'(cmd_ready_o), 1);
    check("t8_rst_bytes", 32'(bytes_rcvd_o), 0);
    sb_q.delete();
    data_ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
